// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared types, defaults and hazard helper for the stall controller
// Busy-sequencer state encoding plus the Tuse/Tnew dependency check used for rs and rt.
package pipe_stall_ctrl_pkg;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;
  localparam int unsigned CNT_W_DEF    = 4;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2
  } md_state_t;

  // $0 is hard-wired, so a producer "writing" it can never be a real dependency.
  function automatic logic reg_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] a3_ex,
    input logic [1:0] tnew_ex,
    input logic [4:0] a3_mem,
    input logic [1:0] tnew_mem
  );
    return (src != 5'd0) &&
           (((src == a3_ex)  && (tuse < tnew_ex)) ||
            ((src == a3_mem) && (tuse < tnew_mem)));
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - ID-stage hazard inputs and front-end gating outputs
// master = decoder/pipeline side driving hazard info; slave = the stall controller.
interface pipe_stall_ctrl_if;

  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic [1:0]  tuse_rs;
  logic [1:0]  tuse_rt;
  logic [4:0]  a3_ex;
  logic [1:0]  tnew_ex;
  logic [4:0]  a3_mem;
  logic [1:0]  tnew_mem;
  logic        md_use_id;
  logic        md_start_ex;
  logic        md_is_div;
  logic        stall;
  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_clr;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output rs_id, rt_id, tuse_rs, tuse_rt, a3_ex, tnew_ex, a3_mem, tnew_mem,
           md_use_id, md_start_ex, md_is_div,
    input  stall, pc_en, if_id_en, id_ex_clr, md_busy, stall_cnt
  );

  modport slave (
    input  rs_id, rt_id, tuse_rs, tuse_rt, a3_ex, tnew_ex, a3_mem, tnew_mem,
           md_use_id, md_start_ex, md_is_div,
    output stall, pc_en, if_id_en, id_ex_clr, md_busy, stall_cnt
  );

endinterface

// File: rtl/pipe_stall_ctrl_md_busy_timer.sv
// rtl/pipe_stall_ctrl_md_busy_timer.sv - HI/LO unit busy sequencer
// A start in cycle t keeps o_busy high for t+1..t+LAT; starts while busy are dropped.
module pipe_stall_ctrl_md_busy_timer
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy
);

  md_state_t        r_state;
  md_state_t        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      MD_IDLE: begin
        if (i_start && !i_is_div) begin
          w_state_next = MD_MULT;
          w_cnt_next   = CNT_W'(MULT_LAT - 1);
        end else if (i_start && i_is_div) begin
          w_state_next = MD_DIV;
          w_cnt_next   = CNT_W'(DIV_LAT - 1);
        end
      end
      MD_MULT, MD_DIV: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else begin
          w_state_next = MD_IDLE;
        end
      end
      default: begin
        w_state_next = MD_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_busy = (r_state != MD_IDLE);

  // The front-end stall should make this impossible; seeing it means a decoder/stall bug.
  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (reset) !(i_start && o_busy)
  );

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - MIPS 5-stage stall controller top
// Combines rs/rt Tuse-Tnew hazards with the mult/div busy sequencer and counts stalled cycles.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  pipe_stall_ctrl_if.slave   bus
);

  logic        w_stall_rs;
  logic        w_stall_rt;
  logic        w_stall_md;
  logic        w_stall_raw;
  logic        w_stall;
  logic        w_md_busy;
  logic [31:0] r_stall_cnt;

  pipe_stall_ctrl_md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_timer (
    .clk      (clk),
    .reset    (reset),
    .i_start  (bus.md_start_ex),
    .i_is_div (bus.md_is_div),
    .o_busy   (w_md_busy)
  );

  assign w_stall_rs = reg_hazard(bus.rs_id, bus.tuse_rs, bus.a3_ex, bus.tnew_ex,
                                 bus.a3_mem, bus.tnew_mem);
  assign w_stall_rt = reg_hazard(bus.rt_id, bus.tuse_rt, bus.a3_ex, bus.tnew_ex,
                                 bus.a3_mem, bus.tnew_mem);
  // The start cycle itself blocks through md_start_ex, before busy is registered.
  assign w_stall_md  = bus.md_use_id && (bus.md_start_ex || w_md_busy);
  assign w_stall_raw = w_stall_rs || w_stall_rt || w_stall_md;
  assign w_stall     = !reset && w_stall_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // During reset the ID/EX register is held clear while the front end runs freely.
  assign bus.stall     = w_stall;
  assign bus.pc_en     = !w_stall;
  assign bus.if_id_en  = !w_stall;
  assign bus.id_ex_clr = reset || w_stall;
  assign bus.md_busy   = w_md_busy;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_pipe_stall_ctrl;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        busy;
    logic [31:0] cnt;
    int          id;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   n_vec;
  int   n_bad;
  int   vec_id;
  logic [31:0] cnt_model;

  pipe_stall_ctrl_if u_if ();

  pipe_stall_ctrl #(
    .MULT_LAT (5),
    .DIV_LAT  (10),
    .CNT_W    (4)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic vec(
    input logic       rst,
    input logic [4:0] rs,  input logic [1:0] tur,
    input logic [4:0] rt,  input logic [1:0] tut,
    input logic [4:0] ae,  input logic [1:0] te,
    input logic [4:0] am,  input logic [1:0] tm,
    input logic mu, input logic ms, input logic md,
    input logic es, input logic eb
  );
    exp_t e;
    @(posedge clk);
    #1;
    reset            = rst;
    u_if.rs_id       = rs;
    u_if.tuse_rs     = tur;
    u_if.rt_id       = rt;
    u_if.tuse_rt     = tut;
    u_if.a3_ex       = ae;
    u_if.tnew_ex     = te;
    u_if.a3_mem      = am;
    u_if.tnew_mem    = tm;
    u_if.md_use_id   = mu;
    u_if.md_start_ex = ms;
    u_if.md_is_div   = md;
    e.rst   = rst;
    e.stall = es;
    e.busy  = eb;
    e.cnt   = cnt_model;
    e.id    = vec_id;
    vec_id++;
    if (rst) cnt_model = 32'd0;
    else if (es) cnt_model = cnt_model + 32'd1;
    sb.push_back(e);
  endtask

  task automatic idle(input logic rst, input logic mu, input logic ms, input logic md,
                      input logic es, input logic eb);
    vec(rst, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, mu, ms, md, es, eb);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (u_if.stall !== e.stall) begin
        n_bad++;
        $display("FAIL v%0d stall: got %b want %b", e.id, u_if.stall, e.stall);
      end
      if (u_if.pc_en !== !e.stall) begin
        n_bad++;
        $display("FAIL v%0d pc_en: got %b want %b", e.id, u_if.pc_en, !e.stall);
      end
      if (u_if.if_id_en !== !e.stall) begin
        n_bad++;
        $display("FAIL v%0d if_id_en: got %b want %b", e.id, u_if.if_id_en, !e.stall);
      end
      if (u_if.id_ex_clr !== (e.rst | e.stall)) begin
        n_bad++;
        $display("FAIL v%0d id_ex_clr: got %b want %b", e.id, u_if.id_ex_clr, e.rst | e.stall);
      end
      if (u_if.md_busy !== e.busy) begin
        n_bad++;
        $display("FAIL v%0d md_busy: got %b want %b", e.id, u_if.md_busy, e.busy);
      end
      if (u_if.stall_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL v%0d stall_cnt: got %0d want %0d", e.id, u_if.stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    int guard;
    n_vec = 0; n_bad = 0; vec_id = 0; cnt_model = 32'd0;
    reset = 1'b1;
    u_if.rs_id = 5'd0; u_if.rt_id = 5'd0; u_if.tuse_rs = 2'd3; u_if.tuse_rt = 2'd3;
    u_if.a3_ex = 5'd0; u_if.tnew_ex = 2'd0; u_if.a3_mem = 5'd0; u_if.tnew_mem = 2'd0;
    u_if.md_use_id = 1'b0; u_if.md_start_ex = 1'b0; u_if.md_is_div = 1'b0;

    // reset forces outputs regardless of hazardous inputs
    vec(1, 5'd1, 2'd0, 5'd0, 2'd3, 5'd1, 2'd2, 5'd0, 2'd0, 1, 1, 0, 0, 0);
    idle(1, 0, 0, 0, 0, 0);
    // lw $1 then beq $1,$2: two stall cycles as tnew drains
    vec(0, 5'd1, 2'd0, 5'd2, 2'd0, 5'd1, 2'd2, 5'd0, 2'd0, 0, 0, 0, 1, 0);
    vec(0, 5'd1, 2'd0, 5'd2, 2'd0, 5'd0, 2'd0, 5'd1, 2'd1, 0, 0, 0, 1, 0);
    vec(0, 5'd1, 2'd0, 5'd2, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 0, 0, 0, 0, 0);
    // $0 never stalls
    vec(0, 5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd2, 5'd0, 2'd0, 0, 0, 0, 0, 0);
    // tuse == tnew boundary, rt via MEM, tnew 3 vs not-used, rt $0 via MEM
    vec(0, 5'd3, 2'd1, 5'd0, 2'd3, 5'd3, 2'd1, 5'd0, 2'd0, 0, 0, 0, 0, 0);
    vec(0, 5'd0, 2'd3, 5'd5, 2'd1, 5'd0, 2'd0, 5'd5, 2'd2, 0, 0, 0, 1, 0);
    vec(0, 5'd0, 2'd3, 5'd5, 2'd3, 5'd5, 2'd3, 5'd0, 2'd0, 0, 0, 0, 0, 0);
    vec(0, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd2, 0, 0, 0, 0, 0);
    // mult at t with mflo in ID: stall t..t+5, busy t+1..t+5
    idle(0, 1, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) idle(0, 1, 0, 0, 1, 1);
    idle(0, 1, 0, 0, 0, 0);
    // div at t, mfhi arrives t+3: stall t+3..t+10
    idle(0, 0, 1, 1, 0, 0);
    idle(0, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) idle(0, 1, 0, 0, 1, 1);
    idle(0, 1, 0, 0, 0, 0);
    // rs hazard overlapping md_busy counts once
    idle(0, 0, 1, 0, 0, 0);
    vec(0, 5'd1, 2'd0, 5'd0, 2'd3, 5'd1, 2'd2, 5'd0, 2'd0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) idle(0, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 0, 0);
    // div aborted by reset at t+4: clean at t+5
    idle(0, 1, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) idle(0, 1, 0, 0, 1, 1);
    idle(1, 1, 0, 0, 0, 1);
    idle(0, 1, 0, 0, 0, 0);
    idle(0, 0, 0, 0, 0, 0);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
